// File: rtl/rect_meter_pkg.sv
// Shared types and helpers for the rectangular pulse meter: FSM state encoding,
// default counter width and a saturating increment.
package rect_meter_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // Width-agnostic: callers widen to 32 bits and narrow the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rect_pulse_meter_if.sv
// Result channel of the pulse meter: measured counts plus valid/ready handshake.
interface rect_pulse_meter_if
  import rect_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [CNT_W-1:0] th_cnt;
  logic [CNT_W-1:0] tl_cnt;
  logic [CNT_W:0]   period_cnt;
  logic             sat;
  logic             meas_valid;
  logic             meas_ready;
  logic             overrun;

  modport master (
    output th_cnt, tl_cnt, period_cnt, sat, meas_valid, overrun,
    input  meas_ready
  );

  modport slave (
    input  th_cnt, tl_cnt, period_cnt, sat, meas_valid, overrun,
    output meas_ready
  );

endinterface

// File: rtl/rect_pulse_meter_edge_deglitch.sv
// Synchroniser plus deglitch filter: produces a filtered level and registered
// one-cycle rise/fall pulses aligned with the cycle the new level appears.
module edge_deglitch #(
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int DG_W = (DEGLITCH < 2) ? 1 : $clog2(DEGLITCH);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [DG_W-1:0]        dg_cnt;
  logic                   synced;

  assign synced = sync_p[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      dg_cnt <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], sig_in};
      rise   <= 1'b0;
      fall   <= 1'b0;
      // Level flips on the DEGLITCH-th consecutive disagreeing sample.
      if (synced != level) begin
        if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
          level  <= synced;
          rise   <= synced;
          fall   <= ~synced;
          dg_cnt <= '0;
        end else begin
          dg_cnt <= dg_cnt + 1'b1;
        end
      end else begin
        dg_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rect_pulse_meter.sv
// Pulse meter top: measures high time, low time and period of a deglitched input
// in clk cycles and presents each completed period on a valid/ready result port.
module rect_pulse_meter
  import rect_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sig_in,
  rect_pulse_meter_if.master  m
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic level, rise, fall;

  edge_deglitch #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEGLITCH   (DEGLITCH)
  ) u_front (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state;
  logic [CNT_W-1:0] th_q, tl_q;

  // Measurement FSM and the two saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      th_q  <= '0;
      tl_q  <= '0;
    end else if (!en) begin
      state <= IDLE;
      th_q  <= '0;
      tl_q  <= '0;
    end else begin
      case (state)
        IDLE: state <= ARM;
        ARM: begin
          if (rise) begin
            state <= HIGH;
            th_q  <= CNT_W'(1);
            tl_q  <= '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            tl_q  <= CNT_W'(1);
          end else if (level) begin
            th_q <= CNT_W'(sat_inc(32'(th_q), CNT_MAX));
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            th_q  <= CNT_W'(1);
            tl_q  <= '0;
          end else begin
            tl_q <= CNT_W'(sat_inc(32'(tl_q), CNT_MAX));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic cap, accept, drop, load;

  assign cap    = en && (state == LOW) && rise;
  assign accept = m.meas_valid && m.meas_ready;
  assign drop   = cap && m.meas_valid && !m.meas_ready;
  assign load   = cap && !drop;

  // armed_q marks that the held result was loaded after an overrun, so its
  // acceptance is the one that clears the sticky flag.
  logic res_valid_q, ovr_q, armed_q;
  logic valid_d, ovr_d, armed_d;

  always_comb begin
    valid_d = res_valid_q;
    ovr_d   = ovr_q;
    armed_d = armed_q;
    if (accept) valid_d = 1'b0;
    if (accept && armed_q) begin
      ovr_d   = 1'b0;
      armed_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      armed_d = ovr_d;
    end
    if (drop) begin
      ovr_d   = 1'b1;
      armed_d = 1'b0;
    end
  end

  logic [CNT_W-1:0] res_th_q, res_tl_q;
  logic [CNT_W:0]   res_per_q;
  logic             res_sat_q;

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      armed_q     <= 1'b0;
      res_th_q    <= '0;
      res_tl_q    <= '0;
      res_per_q   <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      res_valid_q <= valid_d;
      ovr_q       <= ovr_d;
      armed_q     <= armed_d;
      if (load) begin
        res_th_q  <= th_q;
        res_tl_q  <= tl_q;
        res_per_q <= {1'b0, th_q} + {1'b0, tl_q};
        res_sat_q <= (&th_q) | (&tl_q);
      end
    end
  end

  assign m.th_cnt     = res_th_q;
  assign m.tl_cnt     = res_tl_q;
  assign m.period_cnt = res_per_q;
  assign m.sat        = res_sat_q;
  assign m.meas_valid = res_valid_q;
  assign m.overrun    = ovr_q;

endmodule

// File: tb/tb_rect_pulse_meter.sv
// Directed bench for rect_pulse_meter: table of regular waveforms plus
// hand-written sequences for glitches, backpressure, saturation, reset and enable.
module tb_rect_pulse_meter;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic sig_in;

  always #5 clk = ~clk;

  rect_pulse_meter_if #(.CNT_W(16)) m16 ();
  rect_pulse_meter_if #(.CNT_W(4))  m4 ();

  rect_pulse_meter #(.CNT_W(16), .SYNC_STAGES(2), .DEGLITCH(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .m(m16)
  );

  rect_pulse_meter #(.CNT_W(4), .SYNC_STAGES(2), .DEGLITCH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .m(m4)
  );

  typedef struct {
    int th;
    int tl;
    int per;
    int sat;
    int t;
  } res_t;

  typedef struct {
    int hi;
    int lo;
    int exp_th;
    int exp_tl;
    int exp_per;
    int exp_sat;
  } vec_t;

  res_t q[$];
  res_t q4[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && m16.meas_valid && m16.meas_ready)
      q.push_back('{int'(m16.th_cnt), int'(m16.tl_cnt), int'(m16.period_cnt), int'(m16.sat), cyc});
    if (rst_n && m4.meas_valid && m4.meas_ready)
      q4.push_back('{int'(m4.th_cnt), int'(m4.tl_cnt), int'(m4.period_cnt), int'(m4.sat), cyc});
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_res(input string name, input res_t qq[$], input int idx,
                         input int th, input int tl, input int per, input int sat);
    n_chk++;
    if (idx >= qq.size()) begin
      n_fail++;
      $display("FAIL %s: result %0d missing (have %0d), expected th=%0d tl=%0d per=%0d sat=%0d",
               name, idx, qq.size(), th, tl, per, sat);
    end else if (qq[idx].th != th || qq[idx].tl != tl || qq[idx].per != per || qq[idx].sat != sat) begin
      n_fail++;
      $display("FAIL %s: got th=%0d tl=%0d per=%0d sat=%0d, expected th=%0d tl=%0d per=%0d sat=%0d",
               name, qq[idx].th, qq[idx].tl, qq[idx].per, qq[idx].sat, th, tl, per, sat);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    step(n);
  endtask

  task automatic flush();
    en     = 1'b0;
    sig_in = 1'b0;
    step(10);
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5, 3, 5, 3, 8, 0};
    vecs[1] = '{4, 4, 4, 4, 8, 0};
    vecs[2] = '{2, 3, 2, 3, 5, 0};
    vecs[3] = '{10, 6, 10, 6, 16, 0};
    vecs[4] = '{3, 9, 3, 9, 12, 0};
    vecs[5] = '{2, 2, 2, 2, 4, 0};

    rst_n = 1'b0;
    en = 1'b0;
    sig_in = 1'b0;
    m16.meas_ready = 1'b1;
    m4.meas_ready  = 1'b1;
    #2;
    chk("reset_valid", int'(m16.meas_valid), 0);
    chk("reset_th", int'(m16.th_cnt), 0);
    chk("reset_period", int'(m16.period_cnt), 0);
    chk("reset_overrun", int'(m16.overrun), 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Regular waveforms: three full periods then a closing rise.
    for (int i = 0; i < 6; i++) begin
      flush();
      q.delete();
      en = 1'b1;
      drive(1'b0, 4);
      for (int p = 0; p < 3; p++) begin
        drive(1'b1, vecs[i].hi);
        drive(1'b0, vecs[i].lo);
      end
      drive(1'b1, 8);
      flush();
      chk($sformatf("vec%0d_count", i), q.size(), 3);
      for (int k = 0; k < 3; k++)
        chk_res($sformatf("vec%0d_res%0d", i, k), q, k,
                vecs[i].exp_th, vecs[i].exp_tl, vecs[i].exp_per, vecs[i].exp_sat);
      if (q.size() >= 2)
        chk($sformatf("vec%0d_spacing", i), q[1].t - q[0].t, vecs[i].hi + vecs[i].lo);
    end

    // 1-cycle low glitch inside a 6-cycle high is ignored.
    flush();
    q.delete();
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 6);
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 8);
    flush();
    chk("glitch1_count", q.size(), 2);
    chk_res("glitch1_res0", q, 0, 6, 3, 9, 0);
    chk_res("glitch1_res1", q, 1, 6, 3, 9, 0);

    // 2-cycle low glitch splits the period.
    q.delete();
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 3);
    drive(1'b1, 8);
    flush();
    chk("glitch2_count", q.size(), 2);
    chk_res("glitch2_res0", q, 0, 3, 2, 5, 0);
    chk_res("glitch2_res1", q, 1, 3, 3, 6, 0);

    // Backpressure: first result held, later ones dropped, overrun sticky.
    q.delete();
    m16.meas_ready = 1'b0;
    en = 1'b1;
    drive(1'b0, 4);
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    drive(1'b1, 8);
    chk("bp_valid_held", int'(m16.meas_valid), 1);
    chk("bp_th_held", int'(m16.th_cnt), 4);
    chk("bp_tl_held", int'(m16.tl_cnt), 4);
    chk("bp_period_held", int'(m16.period_cnt), 8);
    chk("bp_overrun_set", int'(m16.overrun), 1);
    m16.meas_ready = 1'b1;
    step(1);
    m16.meas_ready = 1'b0;
    chk("bp_valid_drop", int'(m16.meas_valid), 0);
    chk("bp_overrun_after_stale", int'(m16.overrun), 1);
    chk("bp_stale_count", q.size(), 1);
    m16.meas_ready = 1'b1;
    flush();
    chk("bp_overrun_idle", int'(m16.overrun), 1);
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 8);
    chk("bp_overrun_cleared", int'(m16.overrun), 0);
    chk_res("bp_next_res", q, 1, 4, 4, 8, 0);

    // Saturation on the narrow instance.
    flush();
    q.delete();
    q4.delete();
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 3);
    drive(1'b1, 20);
    drive(1'b0, 3);
    drive(1'b1, 8);
    flush();
    chk("sat4_count", q4.size(), 2);
    chk_res("sat4_first", q4, 0, 3, 3, 6, 0);
    chk_res("sat4_sat", q4, 1, 15, 3, 18, 1);
    chk_res("sat16_nosat", q, 1, 20, 3, 23, 0);

    // Reset in the middle of a high phase.
    q.delete();
    m16.meas_ready = 1'b0;
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 10);
    chk("rst_pre_valid", int'(m16.meas_valid), 1);
    chk("rst_pre_overrun", int'(m16.overrun), 1);
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    chk("rst_async_valid", int'(m16.meas_valid), 0);
    chk("rst_async_th", int'(m16.th_cnt), 0);
    chk("rst_async_tl", int'(m16.tl_cnt), 0);
    chk("rst_async_overrun", int'(m16.overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m16.meas_ready = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    chk("rst_no_early_valid", q.size(), 0);
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 8);
    chk("rst_count", q.size(), 2);
    chk_res("rst_res0", q, 0, 4, 4, 8, 0);
    chk_res("rst_res1", q, 1, 4, 4, 8, 0);

    // en dropped mid-LOW with a pending result; re-enable while high.
    flush();
    q.delete();
    m16.meas_ready = 1'b0;
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 6);
    en = 1'b0;
    drive(1'b0, 4);
    chk("en_pending_valid", int'(m16.meas_valid), 1);
    chk("en_pending_th", int'(m16.th_cnt), 4);
    drive(1'b1, 8);
    en = 1'b1;
    drive(1'b1, 10);
    chk("en_high_valid_held", int'(m16.meas_valid), 1);
    chk("en_high_tl_held", int'(m16.tl_cnt), 4);
    m16.meas_ready = 1'b1;
    step(1);
    chk("en_pending_count", q.size(), 1);
    chk_res("en_pending_res", q, 0, 4, 4, 8, 0);
    step(1);
    chk("en_no_spurious", int'(m16.meas_valid), 0);
    drive(1'b0, 4);
    drive(1'b1, 4);
    drive(1'b0, 4);
    chk("en_no_capture_first_rise", q.size(), 1);
    drive(1'b1, 8);
    flush();
    chk("en_after_count", q.size(), 2);
    chk_res("en_after_res", q, 1, 4, 4, 8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
